// File: rtl/dataram_banked.sv
// Banked file-register RAM for a PIC16F84-class core.
// Only the GPR window of each bank is backed by storage; every other offset
// reads as zero and ignores writes. The banks can alias one shared array or
// each have their own. After reset, a sequencer writes CLEAR_VALUE to every
// word, and busy stays high until that is finished, so the core never sees
// uninitialised data.
module dataram_banked #(
  parameter int                    ADDR_WIDTH     = 9,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    GPR_BASE       = 12,
  parameter int                    GPR_WORDS      = 68,
  parameter int                    MIRROR_BANKS   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  ponrst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  hit,
  output logic                  busy
);

  // state     | meaning
  // S_CLEAR   | sequencer writing CLEAR_VALUE to mem[counter]; bus ignored
  // S_READY   | normal read/write service
  typedef enum logic {S_CLEAR, S_READY} state_t;

  localparam int BANKS = 2 ** (ADDR_WIDTH - 7);
  localparam int TOTAL = (MIRROR_BANKS != 0) ? GPR_WORDS : GPR_WORDS * BANKS;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW    = ADDR_WIDTH - 7;

  localparam logic [6:0]    GPR_LO   = 7'(GPR_BASE);
  localparam logic [6:0]    GPR_HI   = 7'(GPR_BASE + GPR_WORDS - 1);
  localparam logic [IW-1:0] LAST     = IW'(TOTAL - 1);
  localparam logic [IW-1:0] WORDS_IW = IW'(GPR_WORDS);
  localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  logic [DATA_WIDTH-1:0] mem [TOTAL];

  logic [6:0]            off;
  logic [6:0]            off_rel;
  logic [BW-1:0]         bank;
  logic [IW-1:0]         idx;
  state_t                state, state_nxt;
  logic [IW-1:0]         counter, counter_nxt;
  logic                  mem_we;
  logic [IW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Address decode: GPR window check and flat storage index.
  always_comb begin
    off     = addr[6:0];
    bank    = addr[ADDR_WIDTH-1:7];
    hit     = (off >= GPR_LO) && (off <= GPR_HI);
    off_rel = off - GPR_LO;
    idx     = IW'(off_rel);
    if (MIRROR_BANKS == 0) idx = idx + IW'(bank) * WORDS_IW;
  end

  // State and clear-counter registers.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      state   <= RST_STATE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Next state, and the memory write port that is shared by the sequencer and the bus.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    busy        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = idx;
    mem_wdata   = datain;
    case (state)
      S_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = counter;
        mem_wdata = CLEAR_VALUE;
        // Stop at the last word rather than wrap; reset alone restarts at zero.
        if (counter == LAST) state_nxt = S_READY;
        else                 counter_nxt = counter + IW'(1);
      end
      S_READY: mem_we = write & hit;
      default: state_nxt = S_READY;
    endcase
  end

  // Storage array; not reset, because the sequencer initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Registered read with write-first bypass; SFR/unimplemented reads return zero.
  always_ff @(posedge clk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      dataout <= '0;
    end else if (state == S_READY && read) begin
      if (!hit)       dataout <= '0;
      else if (write) dataout <= datain;
      else            dataout <= mem[idx];
    end
  end

endmodule

// File: tb/tb_dataram_banked.sv
// Directed testbench for dataram_banked. It runs a mirrored instance and an
// independent-bank instance side by side on the same bus.
module tb_dataram_banked;

  logic       clk = 1'b0;
  logic       ponrst_n = 1'b0;
  logic [8:0] addr = '0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] datain = '0;
  logic [7:0] dataout_m, dataout_nm;
  logic       hit_m, hit_nm, busy_m, busy_nm;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dataram_banked #(.MIRROR_BANKS(1)) dut_m (
    .clk(clk), .ponrst_n(ponrst_n), .addr(addr), .read(read), .write(write),
    .datain(datain), .dataout(dataout_m), .hit(hit_m), .busy(busy_m)
  );

  dataram_banked #(.MIRROR_BANKS(0)) dut_nm (
    .clk(clk), .ponrst_n(ponrst_n), .addr(addr), .read(read), .write(write),
    .datain(datain), .dataout(dataout_nm), .hit(hit_nm), .busy(busy_nm)
  );

  typedef struct {
    logic [8:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic       exp_hit;
    logic [7:0] exp_m;
    logic [7:0] exp_nm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until both instances drop busy, or until the cycle budget runs out.
  // Any write/read strobe is removed after cycle 60.
  task automatic wait_clear(output int c_m, output int c_nm);
    c_m = 0;
    c_nm = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (i == 40) check("dataout_during_clear", {24'b0, dataout_m}, 32'h0);
      if (i == 60) begin
        write = 1'b0;
        read  = 1'b0;
      end
      if (c_m == 0 && !busy_m) c_m = i;
      if (c_nm == 0 && !busy_nm) c_nm = i;
      if (c_m != 0 && c_nm != 0) break;
    end
  endtask

  initial begin
    int c_m, c_nm;

    // Reset state
    #2;
    check("reset_dataout_m", {24'b0, dataout_m}, 32'h0);
    check("reset_busy_m", {31'b0, busy_m}, 32'h1);
    check("reset_busy_nm", {31'b0, busy_nm}, 32'h1);

    // Release the reset. Writes and reads are issued while busy and must be ignored.
    tick();
    addr = 9'h020; datain = 8'hAB; write = 1'b1; read = 1'b1;
    ponrst_n = 1'b1;
    wait_clear(c_m, c_nm);
    check("clear_cycles_m", c_m, 68);
    check("clear_cycles_nm", c_nm, 272);

    addr = 9'h020; read = 1'b1; write = 1'b0;
    tick();
    check("read_020_m", {24'b0, dataout_m}, 32'h0);
    check("read_020_nm", {24'b0, dataout_nm}, 32'h0);

    // Table-driven vectors; all memory is CLEAR_VALUE (0) at this point.
    vecs.push_back('{9'h00C, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{9'h08C, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h00});
    vecs.push_back('{9'h00C, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A});
    vecs.push_back('{9'h003, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h5A, 8'h5A});
    vecs.push_back('{9'h003, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{9'h00C, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A});
    vecs.push_back('{9'h04F, 1'b0, 1'b1, 8'h11, 1'b1, 8'h5A, 8'h5A});
    vecs.push_back('{9'h04F, 1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3, 8'hC3});
    vecs.push_back('{9'h04F, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 8'hC3});
    vecs.push_back('{9'h00B, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{9'h050, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{9'h010, 1'b0, 1'b1, 8'h77, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{9'h010, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 8'h77});
    vecs.push_back('{9'h18C, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h77, 8'h77});
    vecs.push_back('{9'h00C, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 8'h5A});
    vecs.push_back('{9'h18C, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 8'h3C});
    vecs.push_back('{9'h1CF, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 8'h00});
    vecs.push_back('{9'h003, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 8'h00});

    foreach (vecs[i]) begin
      addr = vecs[i].addr; read = vecs[i].rd; write = vecs[i].wr; datain = vecs[i].din;
      #1;
      check($sformatf("v%0d_hit_m", i), {31'b0, hit_m}, {31'b0, vecs[i].exp_hit});
      check($sformatf("v%0d_hit_nm", i), {31'b0, hit_nm}, {31'b0, vecs[i].exp_hit});
      tick();
      check($sformatf("v%0d_dout_m", i), {24'b0, dataout_m}, {24'b0, vecs[i].exp_m});
      check($sformatf("v%0d_dout_nm", i), {24'b0, dataout_nm}, {24'b0, vecs[i].exp_nm});
    end

    // Hold: read 0x010 (0x77), then write 0x22 there for 5 cycles with read low.
    addr = 9'h010; read = 1'b1; write = 1'b0;
    tick();
    check("hold_pre", {24'b0, dataout_m}, 32'h77);
    read = 1'b0; write = 1'b1; datain = 8'h22;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_%0d", k), {24'b0, dataout_m}, 32'h77);
    end
    write = 1'b0; read = 1'b1;
    tick();
    check("hold_post_read", {24'b0, dataout_m}, 32'h22);
    read = 1'b0;

    // Asynchronous reset clears dataout immediately, with no clock edge.
    ponrst_n = 1'b0;
    #1;
    check("async_rst_dataout", {24'b0, dataout_m}, 32'h0);
    check("async_rst_busy", {31'b0, busy_m}, 32'h1);
    tick();
    ponrst_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    // Counter is 30 here; reset again and the sequence must restart from zero.
    ponrst_n = 1'b0;
    #1;
    check("midclear_busy", {31'b0, busy_m}, 32'h1);
    tick();
    ponrst_n = 1'b1;
    wait_clear(c_m, c_nm);
    check("reclear_cycles_m", c_m, 68);
    check("reclear_cycles_nm", c_nm, 272);

    addr = 9'h010; read = 1'b1;
    tick();
    check("reclear_010", {24'b0, dataout_m}, 32'h0);
    addr = 9'h00B; read = 1'b0;
    #1;
    check("bound_00B_hit", {31'b0, hit_m}, 32'h0);
    addr = 9'h050;
    #1;
    check("bound_050_hit", {31'b0, hit_m}, 32'h0);
    addr = 9'h04F;
    #1;
    check("bound_04F_hit", {31'b0, hit_m}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
